// File: rtl/mc_alu_pkg.sv
// ---------------------------------------------------------------------------
// mc_alu_pkg
// Purpose : shared opcode and controller-state definitions for the
//           multi-cycle ALU and anything else that speaks its opcode set.
// Contents: ALU_OP_W   - opcode width
//           alu_op_t   - opcode encoding
//           alu_state_t- controller states of mc_alu
// ---------------------------------------------------------------------------
package mc_alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SLL = 4'b0011,
    OP_SRL = 4'b0100,
    OP_SRA = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_MUL = 4'b1000,
    OP_NOR = 4'b1100
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } alu_state_t;

endpackage

// File: rtl/mc_alu_mul.sv
// ---------------------------------------------------------------------------
// mc_alu_mul
// Purpose : iterative shift-add multiplier, one multiplier bit per cycle.
//           Returns the low REG_WIDTH bits of the unsigned product.
// Ports   : clk, reset_b      - clock, async active-low reset
//           start             - load operands and begin (ignored if running)
//           multiplicand      - operand A, captured on start
//           multiplier        - operand B, captured on start
//           done              - high during the final iteration cycle
//           product           - product value valid while done is high
// ---------------------------------------------------------------------------
module mc_alu_mul #(
  parameter int REG_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 start,
  input  logic [REG_WIDTH-1:0] multiplicand,
  input  logic [REG_WIDTH-1:0] multiplier,
  output logic                 done,
  output logic [REG_WIDTH-1:0] product
);

  localparam int CW = $clog2(REG_WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(REG_WIDTH - 1);

  logic [REG_WIDTH-1:0] acc_reg;
  logic [REG_WIDTH-1:0] mcand_reg;
  logic [REG_WIDTH-1:0] mplier_reg;
  logic [CW-1:0]        cnt_reg;
  logic                 run_reg;
  logic [REG_WIDTH-1:0] step_sum;

  // Partial sum including the current bit; on the last iteration this is
  // the finished product, so the caller can register it on the same edge.
  assign step_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign done     = run_reg && (cnt_reg == LAST_ITER);
  assign product  = step_sum;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      run_reg    <= 1'b0;
    end else if (start && !run_reg) begin
      acc_reg    <= '0;
      mcand_reg  <= multiplicand;
      mplier_reg <= multiplier;
      cnt_reg    <= '0;
      run_reg    <= 1'b1;
    end else if (run_reg) begin
      acc_reg    <= step_sum;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      // Wraps back to zero after the last iteration, ready for the next run.
      cnt_reg    <= cnt_reg + 1'b1;
      if (done) begin
        run_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mc_alu.sv
// ---------------------------------------------------------------------------
// mc_alu
// Purpose : multi-cycle ALU with valid/ready handshakes. Single-cycle ops
//           complete one cycle after accept; MUL runs through mc_alu_mul.
// Ports   : clk, reset_b          - clock, async active-low reset
//           in_valid / in_ready   - request handshake (ready only in IDLE)
//           in1, in2, alu_control - operands and opcode, captured at accept
//           out_valid / out_ready - result handshake (valid only in HOLD)
//           result, zero, illegal - registered result, result==0, bad opcode
// ---------------------------------------------------------------------------
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int REG_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] in1,
  input  logic [REG_WIDTH-1:0] in2,
  input  logic [ALU_OP_W-1:0]  alu_control,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_WIDTH-1:0] result,
  output logic                 zero,
  output logic                 illegal
);

  localparam int SHW = $clog2(REG_WIDTH);

  alu_state_t           state_reg, state_next;
  logic [REG_WIDTH-1:0] result_reg;
  logic                 illegal_reg;
  logic [REG_WIDTH-1:0] alu_result;
  logic                 alu_illegal;
  logic [REG_WIDTH-1:0] mul_product;
  logic                 mul_done;
  logic                 accept;
  logic                 is_mul;
  logic [SHW-1:0]       shamt;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == HOLD);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (alu_control == OP_MUL);
  assign shamt     = in2[SHW-1:0];

  assign result  = result_reg;
  assign zero    = (result_reg == '0);
  assign illegal = illegal_reg;

  // Single-cycle datapath; evaluated on the live inputs and registered on
  // the accept edge, which is what freezes the operands.
  always_comb begin
    alu_result  = '0;
    alu_illegal = 1'b0;
    case (alu_control)
      OP_AND:  alu_result = in1 & in2;
      OP_OR:   alu_result = in1 | in2;
      OP_ADD:  alu_result = in1 + in2;
      OP_SUB:  alu_result = in1 - in2;
      OP_NOR:  alu_result = ~(in1 | in2);
      OP_SLT:  alu_result = {{(REG_WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLL:  alu_result = in1 << shamt;
      OP_SRL:  alu_result = in1 >> shamt;
      OP_SRA:  alu_result = $signed(in1) >>> shamt;
      OP_MUL:  alu_result = '0;  // produced by mc_alu_mul
      default: alu_illegal = 1'b1;
    endcase
  end

  mc_alu_mul #(
    .REG_WIDTH(REG_WIDTH)
  ) u_mul (
    .clk         (clk),
    .reset_b     (reset_b),
    .start       (accept && is_mul),
    .multiplicand(in1),
    .multiplier  (in2),
    .done        (mul_done),
    .product     (mul_product)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = is_mul ? BUSY : HOLD;
      BUSY:    if (mul_done) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output register only changes when entering HOLD, so it is naturally
  // stable for as long as the consumer applies backpressure.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      result_reg  <= '0;
      illegal_reg <= 1'b0;
    end else if (accept && !is_mul) begin
      result_reg  <= alu_result;
      illegal_reg <= alu_illegal;
    end else if ((state_reg == BUSY) && mul_done) begin
      result_reg  <= mul_product;
      illegal_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// ---------------------------------------------------------------------------
// tb_mc_alu
// Purpose : self-checking bench for mc_alu: directed cases followed by
//           randomized requests compared against an arithmetic reference.
// ---------------------------------------------------------------------------
module tb_mc_alu;
  import mc_alu_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset_b;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [3:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  int n_tests = 0;
  int n_fail  = 0;

  mc_alu #(.REG_WIDTH(W)) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .alu_control(alu_control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: operations written straight from the opcode table.
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, output logic ill);
    int           sh;
    logic [W-1:0] ones;
    logic [W-1:0] r;
    ones = '1;
    sh   = int'(b % W);
    ill  = 1'b0;
    r    = '0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b1100: r = ~(a | b);
      4'b0111: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'b0011: r = a << sh;
      4'b0100: r = a >> sh;
      4'b0101: begin
        r = a >> sh;
        if (a[W-1]) r = r | ~(ones >> sh);
      end
      4'b1000: r = a * b;
      default: begin r = '0; ill = 1'b1; end
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit bump, output logic [W-1:0] res);
    logic [W-1:0] exp_res;
    logic         exp_ill;
    logic [W-1:0] first_res;
    logic         first_zero;
    logic         first_ill;
    int           exp_lat;
    int           lat;
    int           guard;
    bit           ready_seen;
    bit           stable;

    exp_res = model(op, a, b, exp_ill);
    exp_lat = (op == OP_MUL) ? W + 1 : 1;

    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_before_accept", W'(in_ready), W'(1));

    in_valid = 1'b1; in1 = a; in2 = b; alu_control = op;
    @(posedge clk); #1;
    // Scramble inputs after accept; the captured request must be unaffected.
    in_valid = 1'b0; in1 = rnd64(); in2 = rnd64(); alu_control = 4'($urandom);

    lat = 1;
    ready_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      ready_seen |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", W'(lat), W'(exp_lat));
    check("in_ready_while_busy", W'(ready_seen | in_ready), W'(0));
    check("result", result, exp_res);
    check("zero", W'(zero), W'(exp_res == '0));
    check("illegal", W'(illegal), W'(exp_ill));

    first_res = result; first_zero = zero; first_ill = illegal;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (result !== first_res || zero !== first_zero || illegal !== first_ill ||
          out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) check("backpressure_stable", W'(stable), W'(1));

    // Release; optionally present a request on the same edge, which must be ignored.
    out_ready = 1'b1;
    if (bump) begin
      in_valid = 1'b1; in1 = rnd64(); in2 = rnd64(); alu_control = OP_ADD;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_to_idle", W'({out_valid, in_ready}), W'(2'b01));

    res = first_res;
    $display("[TB] op=%b a=%h b=%h result=%h zero=%0d illegal=%0d lat=%0d hold=%0d",
             op, a, b, first_res, first_zero, first_ill, lat, hold);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] all_ones;

    all_ones = '1;
    reset_b = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; alu_control = '0;
    #2 reset_b = 1'b0;
    #1;
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_result", result, W'(0));
    check("reset_zero", W'(zero), W'(1));
    check("reset_illegal", W'(illegal), W'(0));
    repeat (2) @(posedge clk);
    #1 reset_b = 1'b1;

    // Directed cases; the first one is accepted on the first edge after reset.
    do_op(OP_ADD, 8, 4, 5, 1'b1, r); check("dir_add", r, 12);
    do_op(OP_SUB, 8, 4, 0, 1'b0, r); check("dir_sub", r, 4);
    do_op(OP_AND, 8, 4, 0, 1'b0, r); check("dir_and", r, 0);
    do_op(OP_OR,  8, 4, 1, 1'b0, r); check("dir_or", r, 12);
    do_op(OP_SUB, 8, 8, 0, 1'b0, r); check("dir_sub_zero", r, 0);
    do_op(OP_SLT, all_ones, 1, 0, 1'b0, r); check("dir_slt", r, 1);
    do_op(OP_MUL, 7, 6, 2, 1'b1, r); check("dir_mul", r, 42);
    do_op(OP_ADD, all_ones, 1, 0, 1'b0, r); check("dir_add_wrap", r, 0);
    do_op(4'b1111, 5, 9, 0, 1'b0, r); check("dir_illegal", r, 0);
    do_op(OP_SRA, 64'h8000_0000_0000_0000, 64'hFFC3, 0, 1'b0, r);
    check("dir_sra", r, 64'hF000_0000_0000_0000);

    // Reset in the middle of a multiply.
    in_valid = 1'b1; in1 = 64'd123; in2 = 64'd456; alu_control = OP_MUL;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset_b = 1'b0;
    #1;
    check("midreset_out_valid", W'(out_valid), W'(0));
    check("midreset_in_ready", W'(in_ready), W'(1));
    check("midreset_zero", W'(zero), W'(1));
    @(posedge clk);
    #1 reset_b = 1'b1;
    do_op(OP_ADD, 3, 5, 0, 1'b0, r); check("after_reset_add", r, 8);

    // Randomized requests.
    for (int t = 0; t < 150; t++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) op = OP_MUL;
      case ($urandom_range(0, 3))
        0: begin a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255)); end
        1: begin a = rnd64(); b = a; end
        default: begin a = rnd64(); b = rnd64(); end
      endcase
      do_op(op, a, b, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 64, meaning operand/result width (legal values 8..64, power of two).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_b  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port in1  input  REG_WIDTH  operand 1.
REQ-007 SHALL have port in2  input  REG_WIDTH  operand 2.
REQ-008 SHALL have port alu_control  input  4  operation code.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  REG_WIDTH  operation result.
REQ-012 SHALL have port zero  output  1  high when result is all zeros.
REQ-013 SHALL have port illegal  output  1  high when the completed request had an undefined code.

Function
REQ-014 SHALL decode alu_control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0111 SLT (signed; result 1 or 0), 0011 SLL, 0100 SRL, 0101 SRA, 1000 MUL.
REQ-015 SHALL use in2[$clog2(REG_WIDTH)-1:0] as the shift amount and ignore the upper bits of in2.
REQ-016 SHALL perform ADD, SUB and MUL modulo 2^REG_WIDTH: wrap-around, no carry output. MUL returns the low REG_WIDTH bits of the unsigned product.
REQ-017 SHALL accept a request on a rising edge where in_valid and in_ready are both high.
REQ-018 SHALL capture operands and code at accept, so later changes on in1, in2 or alu_control have no effect.
REQ-019 SHALL implement states IDLE, BUSY and HOLD.
REQ-020 SHALL drive in_ready high only in IDLE.
REQ-021 SHALL drive out_valid high only in HOLD.
REQ-022 SHALL use these transitions:
- IDLE -> HOLD on accepting a non-MUL code.
- IDLE -> BUSY on accepting MUL.
- BUSY -> HOLD when the iteration counter reaches REG_WIDTH-1.
- HOLD -> IDLE when out_ready is high.
- All other cases: remain in the current state.
REQ-023 SHALL give non-MUL operations latency 1: out_valid is high in the cycle after the accept edge.
REQ-024 SHALL compute MUL by shift-add at one multiplier bit per cycle, with out_valid first high exactly REG_WIDTH+1 cycles after the accept edge.
REQ-025 SHALL hold result, zero and illegal stable while out_valid is high and out_ready is low (backpressure, no loss).
REQ-026 SHALL NOT accept a new request in the cycle out_valid and out_ready are both high; in_ready rises in the following cycle (no bypass).
REQ-027 SHALL, for an undefined code, complete with latency 1, result 0, zero 1 and illegal 1.
REQ-028 SHALL compute zero from the registered result, valid whenever out_valid is high.

Reset
REQ-029 SHALL, while reset_b is low, force state IDLE, in_ready 1 (the IDLE value), out_valid 0, result 0, zero 1, illegal 0 and iteration counter 0.
REQ-030 SHALL discard any in-flight operation, including a partial MUL, when reset_b is asserted; no result is produced for it.
REQ-031 SHALL accept a request on the first rising edge after reset_b deasserts.

Structure
REQ-032 SHALL place the opcode enum (alu_op_t) and opcode constants in shared package mc_alu_pkg, reused by benches and future datapath blocks.
REQ-033 SHALL contain one sub-module, mc_alu_mul: an iterative shift-add multiplier with start/done and a $clog2(REG_WIDTH)-bit counter.
REQ-034 SHALL keep the single-cycle operations combinational in mc_alu, feeding the output register.

Verification
REQ-035 SHALL cover single-cycle operations: in1=8, in2=4 with codes 0010, 0110, 0000, 0001 -> result 12, 4, 0 (zero=1), 12, each with out_valid 1 cycle after accept.
REQ-036 SHALL cover zero and signed compare:
- in1=8, in2=8, SUB -> result 0, zero=1.
- in1=-1, in2=1, SLT -> result 1.
REQ-037 SHALL cover MUL: in1=7, in2=6, MUL at REG_WIDTH=64 -> result 42, out_valid first high 65 cycles after accept, in_ready low throughout.
REQ-038 SHALL cover backpressure: out_ready held low 5 cycles after out_valid -> result stable, in_ready low; single out_ready pulse -> IDLE next cycle.
REQ-039 SHALL cover reset mid-operation: reset_b asserted 10 cycles into a MUL -> out_valid 0 and in_ready 1 immediately; next ADD 3+5 returns 8.
REQ-040 SHALL cover wrap-around and illegal code:
- in1 all ones, in2=1, ADD -> result 0, zero=1.
- Code 1111 -> result 0, illegal=1.
